// File: rtl/ysyx_23060075_divider_if.sv
// Request/response bundle for the iterative divider.
// The master issues operands and consumes results; the slave is the divider.
interface ysyx_23060075_divider_if #(
    parameter int data_len = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [data_len-1:0] dividend;
    logic [data_len-1:0] divisor;
    logic                is_signed;
    logic                out_valid;
    logic                out_ready;
    logic [data_len-1:0] quotient;
    logic [data_len-1:0] remainder;

    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/ysyx_23060075_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, with signed and
// unsigned operation, divide-by-zero and signed-overflow shortcuts.

// Add/subtract unit. For subtraction the carry output reports a borrow
// (1 = a < b as unsigned), which is what the divider step consumes.
module ysyx_23060075_adder_alu #(
    parameter int width = 33
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             is_sub,
    output logic [width-1:0] result,
    output logic             carry
);
    logic [width:0]   sum_s;
    logic [width-1:0] b_eff_s;

    // Two's-complement add of a and (optionally inverted) b; carry flipped to borrow on subtract.
    always_comb begin
        if (is_sub) begin
            b_eff_s = ~b;
        end else begin
            b_eff_s = b;
        end
        sum_s  = {1'b0, a} + {1'b0, b_eff_s} + {{width{1'b0}}, is_sub};
        result = sum_s[width-1:0];
        carry  = sum_s[width] ^ is_sub;
    end
endmodule

module ysyx_23060075_divider #(
    parameter int data_len = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    ysyx_23060075_divider_if.slave     bus
);
    localparam int cnt_w = $clog2(data_len + 1);
    localparam logic [cnt_w-1:0]    cnt_init = cnt_w'(data_len);
    localparam logic [cnt_w-1:0]    cnt_one  = {{(cnt_w-1){1'b0}}, 1'b1};
    localparam logic [data_len-1:0] min_neg  = {1'b1, {(data_len-1){1'b0}}};
    localparam logic [data_len-1:0] all_ones = {data_len{1'b1}};
    localparam logic [data_len-1:0] zero_w   = {data_len{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [cnt_w-1:0]    cnt_r;
    logic [data_len:0]   rem_r;        // partial remainder, one guard bit wide
    logic [data_len-1:0] dvd_r;        // dividend magnitude, quotient bits shift in at the bottom
    logic [data_len-1:0] dvs_r;        // divisor magnitude
    logic                signed_r;
    logic                dvd_neg_r;
    logic                dvs_neg_r;
    logic                out_valid_r;
    logic [data_len-1:0] quotient_r;
    logic [data_len-1:0] remainder_r;

    logic [data_len:0]   shift_s;
    logic [data_len:0]   trial_s;
    logic                carry_s;
    logic                borrow_s;
    logic [data_len:0]   next_rem_s;
    logic [data_len-1:0] next_quo_s;
    logic [data_len-1:0] quo_final_s;
    logic [data_len-1:0] rem_final_s;
    logic [data_len-1:0] dvd_mag_s;
    logic [data_len-1:0] dvs_mag_s;
    logic                div_zero_s;
    logic                overflow_s;

    function automatic logic [data_len-1:0] negate(input logic [data_len-1:0] x);
        return ~x + {{(data_len-1){1'b0}}, 1'b1};
    endfunction

    assign bus.in_ready  = (state_r == IDLE) && rst_n;
    assign bus.out_valid = out_valid_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;

    ysyx_23060075_adder_alu #(
        .width (data_len + 1)
    ) u_adder (
        .a      (shift_s),
        .b      ({1'b0, dvs_r}),
        .is_sub (1'b1),
        .result (trial_s),
        .carry  (carry_s)
    );

    // One restoring step plus final sign correction, evaluated from the current registers.
    always_comb begin
        shift_s = {rem_r[data_len-1:0], dvd_r[data_len-1]};
        // The guard bit is never set for legal operands; if it were, the
        // shifted value would certainly exceed the divisor.
        borrow_s = carry_s & ~rem_r[data_len];
        if (borrow_s) begin
            next_rem_s = shift_s;
        end else begin
            next_rem_s = trial_s;
        end
        next_quo_s = {dvd_r[data_len-2:0], ~borrow_s};
        if (signed_r && (dvd_neg_r ^ dvs_neg_r)) begin
            quo_final_s = negate(next_quo_s);
        end else begin
            quo_final_s = next_quo_s;
        end
        if (signed_r && dvd_neg_r) begin
            rem_final_s = negate(next_rem_s[data_len-1:0]);
        end else begin
            rem_final_s = next_rem_s[data_len-1:0];
        end
    end

    // Request decode: operand magnitudes and the two shortcut cases.
    always_comb begin
        if (bus.is_signed && bus.dividend[data_len-1]) begin
            dvd_mag_s = negate(bus.dividend);
        end else begin
            dvd_mag_s = bus.dividend;
        end
        if (bus.is_signed && bus.divisor[data_len-1]) begin
            dvs_mag_s = negate(bus.divisor);
        end else begin
            dvs_mag_s = bus.divisor;
        end
        div_zero_s = (bus.divisor == zero_w);
        overflow_s = bus.is_signed && (bus.dividend == min_neg) && (bus.divisor == all_ones);
    end

    // Control FSM and all datapath registers; reset, then flush, take priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {cnt_w{1'b0}};
            rem_r       <= {(data_len+1){1'b0}};
            dvd_r       <= zero_w;
            dvs_r       <= zero_w;
            signed_r    <= 1'b0;
            dvd_neg_r   <= 1'b0;
            dvs_neg_r   <= 1'b0;
            out_valid_r <= 1'b0;
            quotient_r  <= zero_w;
            remainder_r <= zero_w;
        end else if (flush) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (div_zero_s) begin
                            quotient_r  <= all_ones;
                            remainder_r <= bus.dividend;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else if (overflow_s) begin
                            quotient_r  <= bus.dividend;
                            remainder_r <= zero_w;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            dvd_r     <= dvd_mag_s;
                            dvs_r     <= dvs_mag_s;
                            signed_r  <= bus.is_signed;
                            dvd_neg_r <= bus.is_signed & bus.dividend[data_len-1];
                            dvs_neg_r <= bus.is_signed & bus.divisor[data_len-1];
                            rem_r     <= {(data_len+1){1'b0}};
                            cnt_r     <= cnt_init;
                            state_r   <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_r <= next_rem_s;
                    dvd_r <= next_quo_s;
                    cnt_r <= cnt_r - cnt_one;
                    if (cnt_r == cnt_one) begin
                        quotient_r  <= quo_final_s;
                        remainder_r <= rem_final_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060075_divider.sv
// Directed bench for ysyx_23060075_divider with data_len = 32.
module tb_ysyx_23060075_divider;
    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   errors;
    int   lat;
    logic seen;

    ysyx_23060075_divider_if #(.data_len(32)) bus ();

    ysyx_23060075_divider #(.data_len(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = sgn;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
    endtask

    // Counts edges after the accepting edge until out_valid is seen (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    // A full transaction: issue, wait, compare latency/results, then hand off.
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic [31:0] eq, input logic [31:0] er, input int elat);
        int n;
        issue(a, b, sgn);
        wait_valid(n);
        check({tag, "_lat"}, 32'(n), 32'(elat));
        check({tag, "_q"}, bus.quotient, eq);
        check({tag, "_r"}, bus.remainder, er);
        handshake(tag);
    endtask

    task automatic no_valid_for(input string tag, input int cycles);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = 32'd0;
        bus.divisor   = 32'd0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_remainder", bus.remainder, 32'd0);
        check("rst_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Normal divides: result appears 32 edges after acceptance
        run("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 32);
        run("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32);
        run("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 32);
        run("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 32);
        run("u_min_ones", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 32);
        run("u_ones_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 32);

        // Shortcut cases: result is registered by the accepting edge itself
        run("u5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 0);
        run("s_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0);
        run("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 0);

        // Backpressure: outputs frozen while out_ready stays low
        issue(32'd100, 32'd7, 1'b0);
        check("bp_busy_ready", {31'd0, bus.in_ready}, 32'd0);
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'd32);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_hold_q", bus.quotient, 32'd14);
            check("bp_hold_r", bus.remainder, 32'd2);
            check("bp_hold_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        handshake("bp");

        // Flush during the tenth iteration
        issue(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_idle", {31'd0, bus.in_ready}, 32'd1);
        check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        no_valid_for("flush_quiet", 40);

        // Flush beats a simultaneous request in IDLE
        bus.dividend  = 32'd9;
        bus.divisor   = 32'd3;
        bus.is_signed = 1'b0;
        bus.in_valid  = 1'b1;
        flush         = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        flush         = 1'b0;
        check("flush_noaccept", {31'd0, bus.in_ready}, 32'd1);
        no_valid_for("flush_noaccept_quiet", 40);

        // Flush beats out_ready in DONE; result is discarded
        issue(32'd5, 32'd0, 1'b0);
        check("fd_valid", {31'd0, bus.out_valid}, 32'd1);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        check("fd_valid_clear", {31'd0, bus.out_valid}, 32'd0);
        check("fd_idle", {31'd0, bus.in_ready}, 32'd1);

        // Reset in the middle of a divide
        issue(32'd100, 32'd7, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mrst_q", bus.quotient, 32'd0);
        check("mrst_r", bus.remainder, 32'd0);
        check("mrst_idle", {31'd0, bus.in_ready}, 32'd1);
        no_valid_for("mrst_quiet", 40);
        run("mrst_u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
